// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode.
//
// Parameters
//   DATA_W     data width in bits
//   DEPTH      number of entries (power of two, >= 4)
//   AFULL_THR  almost_full  asserts when count >= AFULL_THR
//   AEMPTY_THR almost_empty asserts when count <= AEMPTY_THR
//   FWFT       0 = registered read (dout one cycle after rd_en)
//              1 = first-word-fall-through (head word shown while rd_valid)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   wr_en, din   write request and data
//   rd_en        read request (FWFT: pop head)
//   dout         read data
//   rd_valid     dout holds valid read data
//   full, empty, almost_full, almost_empty   registered status flags
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//   clr_err      clears overflow/underflow (a same-cycle new error wins)
module sync_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 1024,
  parameter int AFULL_THR  = DEPTH - 4,
  parameter int AEMPTY_THR = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THR);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THR);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  count_next;
  logic              wa;
  logic              ra;
  logic [DATA_W-1:0] fwft_head;

  // Accept decisions use the registered full/empty, so a write while full is
  // rejected even if a read frees a slot in the same cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wa          = wr_en && !full;
    ra          = rd_en && !empty;
    count_next  = count;
    rd_ptr_next = rd_ptr;
    unique case ({wa, ra})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    if (ra) rd_ptr_next = rd_ptr + PTR_W'(1);
    // In FWFT mode the head after this edge may be the word being written
    // right now (FIFO empty, or last word popped while writing); bypass din.
    if (wa && (rd_ptr_next == wr_ptr)) fwft_head = din;
    else                                fwft_head = mem[rd_ptr_next];
  end

  // NOTE: the storage array has no reset; its contents are don't-care until
  // written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (rst && wa) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      dout         <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;

      // Flags come from the next-state count so they always agree with count.
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);

      if (FWFT != 0) begin
        rd_valid <= (count_next != '0);
        if (count_next != '0) dout <= fwft_head;
      end else begin
        rd_valid <= ra;
        if (ra) dout <= mem[rd_ptr];
      end

      // Set has priority over clear.
      overflow  <= (wr_en && full)  || (overflow  && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one registered-read
// instance and one FWFT instance, DATA_W=8, DEPTH=8, AFULL_THR=6, AEMPTY_THR=2.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Registered-read instance.
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0, dout;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic       overflow, underflow;
  logic [3:0] count;

  // FWFT instance.
  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow;
  logic [3:0] f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en), .dout(f_dout),
    .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow), .clr_err(f_clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_dout"}, dout, exp);
  endtask

  // Safety net: the directed run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    rst = 1'b1;

    // Reset state.
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // Read while empty sets underflow; clr_err clears it.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
    check("udf_valid", rd_valid, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("udf_clr", underflow, 0);

    // Fill 0x01..0x08 and watch the thresholds.
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      check($sformatf("fill%0d_count", i), count, i);
      check($sformatf("fill%0d_afull", i), almost_full, (i >= 6) ? 1 : 0);
      check($sformatf("fill%0d_aempty", i), almost_empty, (i <= 2) ? 1 : 0);
      check($sformatf("fill%0d_full", i), full, (i == 8) ? 1 : 0);
    end

    // Write while full is rejected.
    push(8'hFF);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 8);
    check("ovf_full", full, 1);

    // Drain with rd_en held: one word per cycle, in order.
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("drain%0d_valid", i), rd_valid, 1);
      check($sformatf("drain%0d_dout", i), dout, i);
      check($sformatf("drain%0d_count", i), count, 8 - i);
    end
    rd_en = 1'b0;
    tick();
    check("drain_valid_low", rd_valid, 0);
    check("drain_dout_hold", dout, 8'h08);
    check("drain_empty", empty, 1);
    check("drain_ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_clr", overflow, 0);

    // Wrap-around: second batch crosses the pointer wrap.
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) pop_check($sformatf("wrapA%0d", i), 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) pop_check($sformatf("wrapB%0d", i), 8'(8'hA0 + i));
    tick();
    check("wrap_count", count, 0);
    check("wrap_empty", empty, 1);

    // Simultaneous read/write at count 3.
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1;
      din   = 8'(8'h40 + k);
      rd_en = 1'b1;
      tick();
      check($sformatf("rw%0d_count", k), count, 3);
      check($sformatf("rw%0d_dout", k), dout, (k < 3) ? (8'h30 + k) : (8'h40 + k - 3));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) pop_check($sformatf("rwtail%0d", i), 8'(8'h47 + i));
    check("rw_empty", empty, 1);

    // Full with both asserted: only the read is accepted.
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    check("full2_full", full, 1);
    check("full2_ovf_pre", overflow, 0);
    wr_en = 1'b1;
    din   = 8'hEE;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("full2_count", count, 7);
    check("full2_ovf", overflow, 1);
    check("full2_dout", dout, 8'h50);
    check("full2_notfull", full, 0);
    for (int i = 1; i < 8; i++) pop_check($sformatf("full2_drain%0d", i), 8'(8'h50 + i));
    check("full2_empty", empty, 1);

    // Reset mid-fill discards contents and clears flags.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check("mid_count5", count, 5);
    check("mid_udf_pre", underflow, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_aempty", almost_empty, 1);
    check("mid_ovf", overflow, 0);
    check("mid_udf", underflow, 0);
    check("mid_valid", rd_valid, 0);
    check("mid_dout", dout, 0);
    push(8'h77);
    pop_check("mid_new", 8'h77);
    tick();
    check("mid_new_empty", empty, 1);

    // FWFT instance.
    check("f_rst_valid", f_rd_valid, 0);
    check("f_rst_empty", f_empty, 1);
    f_wr_en = 1'b1;
    f_din   = 8'h5A;
    tick();
    f_wr_en = 1'b0;
    check("f_fall_valid", f_rd_valid, 1);
    check("f_fall_dout", f_dout, 8'h5A);
    check("f_fall_count", f_count, 1);
    tick();
    check("f_hold_dout", f_dout, 8'h5A);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("f_pop_empty", f_empty, 1);
    check("f_pop_valid", f_rd_valid, 0);
    f_wr_en = 1'b1;
    f_din   = 8'h11;
    tick();
    f_din   = 8'h22;
    tick();
    f_wr_en = 1'b0;
    check("f_two_dout", f_dout, 8'h11);
    check("f_two_count", f_count, 2);
    f_rd_en = 1'b1;
    tick();
    check("f_next_dout", f_dout, 8'h22);
    check("f_next_valid", f_rd_valid, 1);
    tick();
    f_rd_en = 1'b0;
    check("f_last_empty", f_empty, 1);
    check("f_last_valid", f_rd_valid, 0);
    check("f_udf_none", f_underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
